uart_tx: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_byte_fifo.sv | 60 ++++++
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared serial-link constants: bit timing default, 8N1 frame format and
// the transmit FSM state encoding.
package uart_tx_pkg;

    localparam int   DEFAULT_CLKS_PER_BIT = 5208;
    localparam int   DATA_BITS            = 8;
    localparam logic START_LEVEL          = 1'b0;
    localparam logic STOP_LEVEL           = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_byte_fifo.sv
// Small synchronous FIFO with first-word-fall-through output; writes while
// full and reads while empty are ignored.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; frames follow each other with no
// idle gap while the FIFO has data.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_data_valid,
    input  logic [7:0] i_data_byte,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [15:0] LAST_CNT     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] PRE_LAST_CNT = 16'(CLKS_PER_BIT - 2);

    tx_state_e   r_state;
    logic [15:0] r_clk_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_done;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_last;
    logic [7:0]  w_fifo_dout;

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (i_data_valid),
        .din   (i_data_byte),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_last  = (r_clk_cnt == LAST_CNT);
    assign o_ready = !w_full;
    assign o_busy  = (r_state != ST_IDLE) || !w_empty;
    assign o_tx    = r_tx;
    assign o_done  = r_done;

    // Pop when idle, or on the last stop-bit cycle to chain the next frame.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = !w_empty;
            ST_STOP: w_pop = w_last && !w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    // Frame sequencer; r_done is set one cycle early so it lands on the last stop cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_clk_cnt <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= STOP_LEVEL;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == ST_STOP) && (r_clk_cnt == PRE_LAST_CNT);
            case (r_state)
                ST_IDLE: begin
                    r_clk_cnt <= 16'd0;
                    if (w_pop) begin
                        r_shift <= w_fifo_dout;
                        r_tx    <= START_LEVEL;
                        r_state <= ST_START;
                    end else begin
                        r_tx <= STOP_LEVEL;
                    end
                end
                ST_START: begin
                    if (w_last) begin
                        r_clk_cnt <= 16'd0;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_last) begin
                        r_clk_cnt <= 16'd0;
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                            r_tx    <= STOP_LEVEL;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_last) begin
                        r_clk_cnt <= 16'd0;
                        if (w_pop) begin
                            r_shift <= w_fifo_dout;
                            r_tx    <= START_LEVEL;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 16'd1;
                    end
                end
                default: begin
                    r_tx    <= STOP_LEVEL;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: accepted bytes go into a scoreboard queue and a
// line monitor decodes every frame on o_tx and checks it against the queue.
module tb_uart_tx;

    localparam int C     = 8;
    localparam int DEPTH = 4;
    localparam int FLEN  = 10 * C;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       i_data_valid = 1'b0;
    logic [7:0] i_data_byte = 8'd0;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         acc_last = 0;
    int         last_low = 0;
    int         starts[$];
    logic [7:0] sb_q[$];

    logic       prev_tx = 1'b1;
    bit         mon_active = 1'b0;
    int         mon_pos = 0;
    int         mon_low = 0;
    bit         mon_wave_bad = 1'b0;
    bit         mon_done_bad = 1'b0;
    logic [7:0] mon_exp = 8'd0;
    logic [7:0] mon_data = 8'd0;

    uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .i_data_valid (i_data_valid),
        .i_data_byte  (i_data_byte),
        .o_ready      (o_ready),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_lvl(input logic [7:0] b, input int k);
        logic r;
        if (k == 0)      r = 1'b0;
        else if (k >= 9) r = 1'b1;
        else             r = b[k-1];
        return r;
    endfunction

    // Line monitor: acts as the receiver and checks the exact waveform of each frame.
    always @(negedge clock) begin
        if (reset) begin
            mon_active = 1'b0;
            prev_tx    = 1'b1;
        end else begin
            if (o_done) done_cnt++;
            if (!mon_active && prev_tx && !o_tx) begin
                mon_active   = 1'b1;
                mon_pos      = 0;
                mon_low      = 0;
                mon_wave_bad = 1'b0;
                mon_done_bad = 1'b0;
                mon_data     = 8'd0;
                starts.push_back(cyc);
                chk("sb_has_entry", (sb_q.size() > 0), 1'b1);
                if (sb_q.size() > 0) mon_exp = sb_q.pop_front();
            end
            if (mon_active) begin
                if (o_tx !== exp_lvl(mon_exp, mon_pos / C)) mon_wave_bad = 1'b1;
                if (o_tx === 1'b0) mon_low++;
                if ((mon_pos % C) == (C / 2) && (mon_pos / C) >= 1 && (mon_pos / C) <= 8)
                    mon_data[(mon_pos / C) - 1] = o_tx;
                if (o_done !== (mon_pos == FLEN - 1)) mon_done_bad = 1'b1;
                if (mon_pos == FLEN - 1) begin
                    chk("frame_data", mon_data, mon_exp);
                    chk("frame_wave", mon_wave_bad, 1'b0);
                    chk("frame_done", mon_done_bad, 1'b0);
                    last_low   = mon_low;
                    mon_active = 1'b0;
                end
                mon_pos++;
            end
            prev_tx = o_tx;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic put(input logic [7:0] b, input int budget);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        i_data_valid = 1'b1;
        i_data_byte  = b;
        while (!ok && n < budget) begin
            if (o_ready) begin
                sb_q.push_back(b);
                acc_last = cyc + 1;
                ok = 1'b1;
            end
            tick();
            n++;
        end
        chk("put_accept", ok, 1'b1);
    endtask

    task automatic wait_done(input int target, input int budget, output int busy_low);
        int n;
        n = 0;
        busy_low = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
            if (!o_busy) busy_low++;
        end
        chk("done_wait", (done_cnt >= target), 1'b1);
    endtask

    initial begin
        int d0;
        int f0;
        int bl;
        int n;
        int acc6;

        repeat (3) tick();
        chk("rst_tx", o_tx, 1'b1);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        reset = 1'b0;
        repeat (3) tick();

        // Single 0x55: latency, framing and done position come from the monitor.
        d0 = done_cnt; f0 = starts.size();
        put(8'h55, 10);
        i_data_valid = 1'b0;
        wait_done(d0 + 1, 200, bl);
        chk("lat_55", starts[f0], acc_last + 1);
        tick();
        chk("busy_fall_55", o_busy, 1'b0);
        repeat (10) tick();
        chk("done_once_55", done_cnt, d0 + 1);

        d0 = done_cnt;
        put(8'hA3, 10);
        i_data_valid = 1'b0;
        wait_done(d0 + 1, 200, bl);
        repeat (5) tick();

        // Burst of three on consecutive cycles.
        d0 = done_cnt; f0 = starts.size();
        put(8'h01, 10);
        put(8'h02, 10);
        put(8'h03, 10);
        i_data_valid = 1'b0;
        wait_done(d0 + 3, 400, bl);
        chk("burst_busy_low", bl, 0);
        chk("burst_pitch1", starts[f0 + 1] - starts[f0], FLEN);
        chk("burst_pitch2", starts[f0 + 2] - starts[f0 + 1], FLEN);
        tick();
        chk("burst_busy_fall", o_busy, 1'b0);
        repeat (5) tick();
        chk("burst_done_cnt", done_cnt, d0 + 3);

        // FIFO full: sixth byte held under valid until the next pop.
        d0 = done_cnt; f0 = starts.size();
        put(8'h10, 10);
        put(8'h21, 10);
        put(8'h32, 10);
        put(8'h43, 10);
        put(8'h54, 10);
        chk("full_ready_low", o_ready, 1'b0);
        put(8'h65, 200);
        acc6 = acc_last;
        i_data_valid = 1'b0;
        chk("full_acc6", acc6, starts[f0 + 1] + 1);
        wait_done(d0 + 6, 800, bl);
        chk("full_busy_low", bl, 0);
        repeat (5) tick();
        chk("full_sb_empty", sb_q.size(), 0);

        // Reset in the middle of data bit 3 with a second byte still queued.
        f0 = starts.size();
        put(8'h35, 10);
        put(8'h77, 10);
        i_data_valid = 1'b0;
        n = 0;
        while (starts.size() == f0 && n < 50) begin
            tick();
            n++;
        end
        chk("mid_frame_started", (starts.size() > f0), 1'b1);
        repeat (35) tick();
        chk("mid_bit3_low", o_tx, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", o_tx, 1'b1);
        chk("mid_rst_ready", o_ready, 1'b1);
        chk("mid_rst_busy", o_busy, 1'b0);
        sb_q.delete();
        d0 = done_cnt;
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        chk("mid_no_done", done_cnt, d0);
        chk("mid_idle_tx", o_tx, 1'b1);
        chk("mid_idle_busy", o_busy, 1'b0);
        put(8'hFF, 10);
        i_data_valid = 1'b0;
        wait_done(d0 + 1, 200, bl);
        chk("ff_low_cycles", last_low, C);
        repeat (5) tick();

        d0 = done_cnt;
        put(8'h00, 10);
        i_data_valid = 1'b0;
        wait_done(d0 + 1, 200, bl);
        chk("zero_low_cycles", last_low, 9 * C);
        repeat (5) tick();
        chk("final_sb_empty", sb_q.size(), 0);
        chk("final_busy", o_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
